// File: rtl/frame_rr_arbiter.sv
// Frame-granular round-robin arbiter: merges NUM_SRC AXI-Stream sources onto one
// output, holding each grant for a whole frame and inserting idle gap cycles after it.
module frame_rr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_NUM   = DATA_WIDTH / 8,
  parameter int NUM_SRC    = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC*BYTE_NUM-1:0]   s_axis_tkeep,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_length,
  input  logic [7:0]                    gap_cycles,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [BYTE_NUM-1:0]           m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_length,
  output logic [NUM_SRC-1:0]            grant,
  output logic                          frame_done,
  output logic                          len_err
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int LW = DATA_WIDTH + 1;
  localparam int CW = (LW > 16) ? LW : 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Extra headroom bit keeps the round-up add from wrapping on huge lengths.
  function automatic logic [LW-1:0] exp_beats(input logic [DATA_WIDTH-1:0] len);
    logic [LW-1:0] b;
    b = ({1'b0, len} + LW'(BYTE_NUM - 1)) / LW'(BYTE_NUM);
    return (b == '0) ? LW'(1) : b;
  endfunction

  state_t                 state_q, state_d;
  logic [NUM_SRC-1:0]     grant_q, grant_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [IW-1:0]          last_grant_q, last_grant_d;
  logic [15:0]            beat_cnt_q, beat_cnt_d;
  logic [7:0]             gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0]  m_length_q, m_length_d;
  logic [LW-1:0]          exp_q, exp_d;
  logic                   frame_done_q, frame_done_d;
  logic                   len_err_q, len_err_d;

  logic [DATA_WIDTH-1:0]  src_data [NUM_SRC];
  logic [BYTE_NUM-1:0]    src_keep [NUM_SRC];
  logic [DATA_WIDTH-1:0]  src_len  [NUM_SRC];

  logic                   pick_found;
  logic [IW-1:0]          pick_idx;
  logic [IW-1:0]          cand_idx;
  int                     cand;
  logic                   hs;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      src_keep[i] = s_axis_tkeep[i*BYTE_NUM +: BYTE_NUM];
      src_len[i]  = s_length[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Rotating priority: search upward from the source after the last owner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand     = (int'(last_grant_q) + 1 + k) % NUM_SRC;
      cand_idx = IW'(cand);
      if (!pick_found && s_axis_tvalid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign hs = (state_q == SEND) && s_axis_tvalid[gidx_q] && m_axis_tready;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    m_length_d   = m_length_q;
    exp_d        = exp_q;
    frame_done_d = 1'b0;
    len_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = SEND;
          grant_d    = NUM_SRC'(1) << pick_idx;
          gidx_d     = pick_idx;
          m_length_d = src_len[pick_idx];
          exp_d      = exp_beats(src_len[pick_idx]);
          beat_cnt_d = '0;
        end
      end
      SEND: begin
        if (hs) begin
          beat_cnt_d = sat_inc16(beat_cnt_q);
          if (s_axis_tlast[gidx_q]) begin
            frame_done_d = 1'b1;
            len_err_d    = (CW'(sat_inc16(beat_cnt_q)) != CW'(exp_q));
            last_grant_d = gidx_q;
            grant_d      = '0;
            gap_cnt_d    = gap_cycles;
            state_d      = (gap_cycles != 8'd0) ? GAP : IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q <= 8'd1) begin
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      gidx_q       <= '0;
      last_grant_q <= IW'(NUM_SRC - 1);
      beat_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      m_length_q   <= '0;
      exp_q        <= '0;
      frame_done_q <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gidx_q       <= gidx_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      m_length_q   <= m_length_d;
      exp_q        <= exp_d;
      frame_done_q <= frame_done_d;
      len_err_q    <= len_err_d;
    end
  end

  // Output path is a pure mux on the granted source; nothing leaks outside SEND.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state_q == SEND) begin
      m_axis_tdata          = src_data[gidx_q];
      m_axis_tkeep          = src_keep[gidx_q];
      m_axis_tvalid         = s_axis_tvalid[gidx_q];
      m_axis_tlast          = s_axis_tlast[gidx_q];
      s_axis_tready[gidx_q] = m_axis_tready;
    end
  end

  assign grant      = grant_q;
  assign m_length   = m_length_q;
  assign frame_done = frame_done_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_frame_rr_arbiter.sv
// Randomized bench for frame_rr_arbiter: per-source frame tables feed the DUT and an
// integer-level arbitration model predicts every output cycle.
module tb_frame_rr_arbiter;
  localparam int DW = 32;
  localparam int BN = 4;
  localparam int NS = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NS*DW-1:0]   s_axis_tdata = '0;
  logic [NS*BN-1:0]   s_axis_tkeep = '0;
  logic [NS-1:0]      s_axis_tvalid = '0;
  logic [NS-1:0]      s_axis_tlast = '0;
  logic [NS-1:0]      s_axis_tready;
  logic [NS*DW-1:0]   s_length = '0;
  logic [7:0]         gap_cycles = '0;
  logic [DW-1:0]      m_axis_tdata;
  logic [BN-1:0]      m_axis_tkeep;
  logic               m_axis_tvalid;
  logic               m_axis_tlast;
  logic               m_axis_tready = 1'b0;
  logic [DW-1:0]      m_length;
  logic [NS-1:0]      grant;
  logic               frame_done;
  logic               len_err;

  frame_rr_arbiter #(.DATA_WIDTH(DW), .BYTE_NUM(BN), .NUM_SRC(NS)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready), .s_length(s_length), .gap_cycles(gap_cycles),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .m_length(m_length), .grant(grant),
    .frame_done(frame_done), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Source frame tables: beats per frame and advertised byte length.
  int            qb [NS][$];
  logic [31:0]   ql [NS][$];
  int            cb [NS];
  int            fid [NS];
  logic          tv [NS];
  logic          tl [NS];
  logic [31:0]   td [NS];
  logic [31:0]   sl [NS];
  logic [3:0]    tk [NS];

  int         vprob = 100;
  int         rprob = 100;
  bit         tr_toggle = 1'b0;
  bit         gap_rand = 1'b0;
  logic [7:0] gap_val = 8'd0;
  bit         hold_rst = 1'b1;
  bit         rst_arm = 1'b0;
  int         cyc = 0;

  // Reference model of the arbitration rules.
  int          mo_owner = -1;
  int          mo_last = NS - 1;
  int          mo_phase = 0;
  int          mo_gap = 0;
  int          mo_beats = 0;
  int          mo_expb = 0;
  logic [31:0] mo_len = '0;
  bit          mo_fd = 1'b0;
  bit          mo_le = 1'b0;

  // Logs of what the DUT actually did in the current phase.
  int          ord_q[$];
  int          gapq[$];
  bit          le_q[$];
  logic [31:0] dq[$];
  int          fd_seen = 0;
  int          hs_seen = 0;
  int          zrun = 0;
  logic [NS-1:0] prev_grant = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] data_word(input int s, input int f, input int b);
    return {8'(s + 1), 8'(f), 16'(b) ^ 16'hA5A5};
  endfunction

  function automatic logic [3:0] keep_of(input int f, input int b, input int nb);
    logic [3:0] full;
    full = 4'hF;
    return (b == nb - 1) ? (full >> (f % 4)) : full;
  endfunction

  function automatic int onehot_idx(input logic [NS-1:0] g);
    for (int i = 0; i < NS; i++) if (g[i]) return i;
    return -1;
  endfunction

  function automatic bit busy();
    for (int i = 0; i < NS; i++) if (qb[i].size() != 0) return 1'b1;
    return (mo_phase != 0) || (mo_owner >= 0);
  endfunction

  task automatic push_frame(input int s, input int nb, input logic [31:0] len);
    qb[s].push_back(nb);
    ql[s].push_back(len);
  endtask

  task automatic cycle();
    logic [NS-1:0] eg, er;
    bit ev, hs, lastb, found;
    int o, c;
    @(posedge clk); #1;
    cyc++;
    rst_n = 1'b1;
    if (hold_rst) rst_n = 1'b0;
    if (rst_arm && mo_owner == 0 && cb[0] == 2) begin
      rst_n = 1'b0;
      rst_arm = 1'b0;
      push_frame(1, 2, 32'd8);
      push_frame(2, 3, 32'd12);
    end
    for (int i = 0; i < NS; i++) begin
      if (qb[i].size() != 0) begin
        tv[i] = ($urandom_range(99) < vprob);
        td[i] = data_word(i, fid[i], cb[i]);
        tk[i] = keep_of(fid[i], cb[i], qb[i][0]);
        tl[i] = (cb[i] == qb[i][0] - 1);
        sl[i] = ql[i][0];
      end else begin
        tv[i] = 1'b0;
        td[i] = $urandom;
        tk[i] = 4'($urandom);
        tl[i] = 1'($urandom);
        sl[i] = $urandom;
      end
      s_axis_tdata[i*DW +: DW] = td[i];
      s_axis_tkeep[i*BN +: BN] = tk[i];
      s_axis_tvalid[i]         = tv[i];
      s_axis_tlast[i]          = tl[i];
      s_length[i*DW +: DW]     = sl[i];
    end
    m_axis_tready = tr_toggle ? cyc[0] : ($urandom_range(99) < rprob);
    gap_cycles = gap_rand ? 8'($urandom_range(3)) : gap_val;
    #1;

    o  = mo_owner;
    eg = (o >= 0) ? (NS'(1) << o) : '0;
    ev = (o >= 0) && tv[o];
    er = (o >= 0 && m_axis_tready) ? eg : '0;
    chk("grant", 64'(grant), 64'(eg));
    chk("m_length", 64'(m_length), 64'(mo_len));
    chk("frame_done", 64'(frame_done), 64'(mo_fd));
    chk("len_err", 64'(len_err), 64'(mo_le));
    chk("m_tvalid", 64'(m_axis_tvalid), 64'(ev));
    chk("s_tready", 64'(s_axis_tready), 64'(er));
    if (o >= 0) begin
      chk("m_tdata", 64'(m_axis_tdata), 64'(td[o]));
      chk("m_tkeep", 64'(m_axis_tkeep), 64'(tk[o]));
      chk("m_tlast", 64'(m_axis_tlast), 64'(tl[o]));
    end else begin
      chk("m_tkeep_idle", 64'(m_axis_tkeep), 64'(0));
      chk("m_tlast_idle", 64'(m_axis_tlast), 64'(0));
    end

    if (grant != '0 && prev_grant == '0) begin
      ord_q.push_back(onehot_idx(grant));
      gapq.push_back(zrun);
      zrun = 0;
    end
    if (grant == '0) zrun++;
    prev_grant = grant;
    if (frame_done) begin
      fd_seen++;
      le_q.push_back(len_err);
    end
    if (m_axis_tvalid && m_axis_tready) begin
      hs_seen++;
      dq.push_back(m_axis_tdata);
    end

    hs = ev && m_axis_tready;
    lastb = (o >= 0) ? tl[o] : 1'b0;
    if (hs) begin
      cb[o]++;
      if (cb[o] == qb[o][0]) begin
        void'(qb[o].pop_front());
        void'(ql[o].pop_front());
        cb[o] = 0;
        fid[o]++;
      end
    end

    mo_fd = 1'b0;
    mo_le = 1'b0;
    if (!rst_n) begin
      mo_owner = -1; mo_last = NS - 1; mo_phase = 0; mo_gap = 0; mo_len = '0;
    end else if (mo_phase == 0) begin
      found = 1'b0;
      for (int k = 0; k < NS; k++) begin
        c = (mo_last + 1 + k) % NS;
        if (!found && tv[c]) begin
          found = 1'b1;
          mo_owner = c;
        end
      end
      if (found) begin
        mo_phase = 1;
        mo_len   = sl[mo_owner];
        mo_expb  = int'((longint'(mo_len) + BN - 1) / BN);
        if (mo_expb == 0) mo_expb = 1;
        mo_beats = 0;
      end
    end else if (mo_phase == 1) begin
      if (hs) begin
        mo_beats++;
        if (lastb) begin
          mo_fd = 1'b1;
          mo_le = (mo_beats != mo_expb);
          mo_last = mo_owner;
          mo_owner = -1;
          if (gap_cycles != 8'd0) begin
            mo_phase = 2;
            mo_gap = int'(gap_cycles);
          end else begin
            mo_phase = 0;
          end
        end
      end
    end else begin
      mo_gap--;
      if (mo_gap == 0) mo_phase = 0;
    end
  endtask

  task automatic run_phase(input string name, input int budget);
    int c;
    c = 0;
    ord_q.delete(); gapq.delete(); le_q.delete(); dq.delete();
    fd_seen = 0; hs_seen = 0; zrun = 0;
    while (c < budget && busy()) begin
      cycle();
      c++;
    end
    repeat (2) cycle();
    chk({name, "_drained"}, 64'(busy()), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int fid0, nb;
    logic [31:0] len;
    for (int i = 0; i < NS; i++) begin
      cb[i] = 0; fid[i] = 0; tv[i] = 1'b0; tl[i] = 1'b0;
      td[i] = '0; sl[i] = '0; tk[i] = '0;
    end

    hold_rst = 1'b1;
    repeat (3) cycle();
    hold_rst = 1'b0;

    // Three equal frames requested together: rotation starts at source 0.
    for (int i = 0; i < NS; i++) push_frame(i, 4, 32'd16);
    run_phase("order", 200);
    chk("order_count", 64'(ord_q.size()), 64'(3));
    for (int k = 0; k < 3; k++) if (ord_q.size() > k) chk("order_src", 64'(ord_q[k]), 64'(k));
    chk("order_fd", 64'(fd_seen), 64'(3));
    foreach (le_q[k]) chk("order_lenerr", 64'(le_q[k]), 64'(0));

    // Lone requester with a 10-cycle gap.
    gap_val = 8'd10;
    for (int f = 0; f < 3; f++) push_frame(1, 2, 32'd8);
    run_phase("gap", 300);
    chk("gap_count", 64'(gapq.size()), 64'(3));
    for (int k = 1; k < 3; k++) if (gapq.size() > k) chk("gap_idle", 64'(gapq[k]), 64'(11));
    gap_val = 8'd0;

    // Length check: 13 bytes fits 4 beats, 20 bytes does not.
    push_frame(2, 4, 32'd13);
    push_frame(2, 4, 32'd20);
    run_phase("length", 200);
    chk("length_fd", 64'(fd_seen), 64'(2));
    if (le_q.size() > 1) begin
      chk("length_ok", 64'(le_q[0]), 64'(0));
      chk("length_bad", 64'(le_q[1]), 64'(1));
    end

    // Downstream stalls every other cycle.
    tr_toggle = 1'b1;
    fid0 = fid[0];
    push_frame(0, 8, 32'd32);
    run_phase("stall", 200);
    chk("stall_hs", 64'(hs_seen), 64'(8));
    for (int k = 0; k < 8; k++) if (dq.size() > k) chk("stall_data", 64'(dq[k]), 64'(data_word(0, fid0, k)));
    tr_toggle = 1'b0;

    // Reset during beat 3 of a source-0 frame.
    push_frame(0, 6, 32'd24);
    rst_arm = 1'b1;
    run_phase("reset", 200);
    chk("reset_ord_count", 64'(ord_q.size()), 64'(4));
    if (ord_q.size() > 2) begin
      chk("reset_first_after", 64'(ord_q[1]), 64'(0));
      chk("reset_second_after", 64'(ord_q[2]), 64'(1));
    end
    chk("reset_fd", 64'(fd_seen), 64'(3));
    if (le_q.size() > 0) chk("reset_remnant_lenerr", 64'(le_q[0]), 64'(1));

    // Random traffic: bubbles, stalls, varying gaps and lengths.
    vprob = 70; rprob = 70; gap_rand = 1'b1;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NS; i++) begin
        nb = $urandom_range(1, 6);
        if ($urandom_range(1) == 1) len = 32'((nb - 1) * BN + $urandom_range(1, BN));
        else len = 32'(nb * BN + $urandom_range(1, 8));
        push_frame(i, nb, len);
      end
    end
    run_phase("random", 4000);

    // Saturated requests: strict rotation.
    vprob = 100; rprob = 80; gap_rand = 1'b0; gap_val = 8'd0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < NS; i++) push_frame(i, $urandom_range(1, 4), 32'd4);
    run_phase("rotate", 1000);
    chk("rotate_count", 64'(ord_q.size()), 64'(9));
    for (int k = 1; k < ord_q.size(); k++)
      chk("rotate_next", 64'(ord_q[k]), 64'((ord_q[k-1] + 1) % NS));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
